// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source with registered, zero-skew counters and sync/blank flags
module vga_timing_gen #(
    parameter int   H_VISIBLE = 800,
    parameter int   H_FRONT   = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BACK    = 88,
    parameter int   V_VISIBLE = 600,
    parameter int   V_FRONT   = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BACK    = 23,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hblnk,
    output logic        vblnk,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    localparam logic [10:0] H_LAST = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] H_BLNK = 11'(H_VISIBLE);
    localparam logic [10:0] H_SS   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SE   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]  V_BLNK = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SS   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hblnk_q, hblnk_d, vblnk_q, vblnk_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        h_last, v_last;

    always_comb begin
        h_last        = hcount_q == H_LAST;
        v_last        = vcount_q == V_LAST;
        hcount_d      = !en ? hcount_q : h_last ? '0 : hcount_q + 11'd1;
        vcount_d      = !(en && h_last) ? vcount_q : v_last ? '0 : vcount_q + 10'd1;
        hblnk_d       = hcount_d >= H_BLNK;
        vblnk_d       = vcount_d >= V_BLNK;
        hsync_d       = (hcount_d >= H_SS && hcount_d < H_SE) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (vcount_d >= V_SS && vcount_d < V_SE) ? VSYNC_POL : ~VSYNC_POL;
        frame_start_d = en && h_last && v_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source of the raster timing bus: hcount, vcount, hblnk, vblnk, hsync, vsync.
- Sits at the head of the video pipeline. Every draw and delay stage downstream consumes its outputs, one register stage per hop.
- Default timing is 800x600 @ 60 Hz with a 40 MHz pixel clock (VESA).
- All outputs are registered and mutually consistent in every cycle.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch in pixels
- H_SYNC, 128, hsync pulse width in pixels
- H_BACK, 88, horizontal back porch in pixels (H_TOTAL = 1056)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 1, vertical front porch in lines
- V_SYNC, 4, vsync pulse width in lines
- V_BACK, 23, vertical back porch in lines (V_TOTAL = 628)
- HSYNC_POL, 1, active level of hsync (1 = active-high)
- VSYNC_POL, 1, active level of vsync

Ports:
- clk  input  1  pixel clock; all logic is on posedge
- rst  input  1  synchronous, active-high reset
- en  input  1  pixel enable; state advances only when en=1
- hcount  output  11  current pixel column, 0..H_TOTAL-1
- vcount  output  10  current line, 0..V_TOTAL-1
- hblnk  output  1  high when hcount >= H_VISIBLE
- vblnk  output  1  high when vcount >= V_VISIBLE
- hsync  output  1  HSYNC_POL when H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, else inverse
- vsync  output  1  VSYNC_POL when V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC, else inverse
- frame_start  output  1  one-cycle pulse on the cycle the outputs show (0,0) after a frame wrap

Behaviour:
- Reset (rst=1 at posedge, with priority over en):
  - hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - Reset asserted mid-frame returns everything to these values on the next edge. There is no partial-line completion.
- Counters, on each posedge with rst=0 and en=1:
  - hcount < H_TOTAL-1: hcount += 1.
  - hcount = H_TOTAL-1: hcount = 0, and vcount += 1. If vcount = V_TOTAL-1, vcount wraps to 0 instead.
- en=0: all outputs hold their previous values, and frame_start is forced to 0.
- Flag decode:
  - hblnk, vblnk, hsync and vsync are computed from the next counter values and registered in the same edge.
  - Net effect: the flags are aligned with the hcount/vcount they describe, with zero skew.
- vblnk and vsync change only on the cycle hcount becomes 0.
- frame_start is 1 only on the cycle following a (H_TOTAL-1, V_TOTAL-1) -> (0,0) transition. It is 0 on the first cycle after reset.
- Latency: 1 cycle from rst deassertion to the first counter advance. The first post-reset edge with en=1 shows hcount=1.
- Arithmetic: the counters never exceed their TOTAL-1. Comparisons are unsigned, against the parameter sums computed at elaboration.
- Defaults: hsync is active for hcount 840..967; vsync is active for vcount 601..604.

Test Plan:
- Reset: hold rst for 3 cycles mid-line (hcount≈500) -> next edge gives hcount=0, vcount=0, all blanks 0, hsync=vsync=0, frame_start=0. After release with en=1, the counters read 1, 2, 3...
- Horizontal decode: free-run one line -> hblnk rises at hcount=800, hsync=1 exactly for hcount 840..967, and at 1055 -> 0 vcount increments by 1 in the same cycle.
- Vertical decode: run 1 frame -> vblnk=1 for vcount 600..627, vsync=1 for vcount 601..604. Both change only at hcount=0.
- Frame wrap: from (1055,627) -> next cycle (0,0) with frame_start=1 for exactly one cycle. The total period is 1056*628 = 663168 cycles between pulses.
- Enable gating: drop en for 5 cycles at (839,10) -> outputs frozen at (839,10) with hsync=0. On re-enable: (840,10) with hsync=1, and no frame_start glitch.
- Polarity: instantiate with HSYNC_POL=0, VSYNC_POL=0 -> reset gives hsync=vsync=1, and the pulses are low over the same ranges.
